// File: rtl/dmem_bus_if.sv
// Load/store bridge from the MEM stage onto the DAD/DDT/MREQ data bus.
// Optional ACKD_n timeout abort enabled by defining DBUS_TIMEOUT_EN.
module dmem_bus_if #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            acc_exc,
  output logic            bus_err,
  output logic [XLEN-1:0] DAD,
  output logic [XLEN-1:0] DDT_out,
  output logic            DDT_oe,
  input  logic [XLEN-1:0] DDT_in,
  output logic            MREQ,
  output logic            WRITE,
  output logic [1:0]      SIZE,
  input  logic            ACKD_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state;
  logic            wr_q;
  logic [2:0]      f3_q;
  logic            align_ok;
  logic            legal;
  logic            accept;
  logic            sgn;
  logic [1:0]      size_c;
  logic [XLEN-1:0] wfmt;
  logic [XLEN-1:0] rext;

  always_comb begin
    align_ok = 1'b0;
    size_c   = 2'b00;
    wfmt     = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        align_ok = 1'b1;
        size_c   = 2'b10;
        wfmt     = {{(XLEN-8){1'b0}}, req_wdata[7:0]};
      end
      2'b01: begin
        align_ok = ~req_addr[0];
        size_c   = 2'b01;
        wfmt     = {{(XLEN-16){1'b0}}, req_wdata[15:0]};
      end
      2'b10: begin
        align_ok = (req_addr[1:0] == 2'b00);
      end
      default: begin
        align_ok = 1'b0;
      end
    endcase
  end

  // funct3[2] is only meaningful as "unsigned" on byte/half loads
  assign legal  = align_ok &
                  ~(req_funct3[2] & (req_write | req_funct3[1]));
  assign accept = (state == IDLE) & req_valid & legal;
  assign stall  = accept | (state == BUSY);
  assign DDT_oe = MREQ & WRITE;

  assign sgn = ~f3_q[2];

  always_comb begin
    rext = DDT_in;
    if (wr_q) begin
      rext = '0;
    end else begin
      case (f3_q[1:0])
        2'b00:   rext = {{(XLEN-8){sgn & DDT_in[7]}},
                         DDT_in[7:0]};
        2'b01:   rext = {{(XLEN-16){sgn & DDT_in[15]}},
                         DDT_in[15:0]};
        default: rext = DDT_in;
      endcase
    end
  end

`ifdef DBUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt;
  logic          bus_err_q;

  assign bus_err = bus_err_q;
`else
  logic unused_tmo;

  assign unused_tmo = (TIMEOUT_CYCLES > 0);
  assign bus_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      f3_q       <= 3'b000;
      MREQ       <= 1'b0;
      WRITE      <= 1'b0;
      SIZE       <= 2'b00;
      DAD        <= '0;
      DDT_out    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      acc_exc    <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      tmo_cnt    <= '0;
      bus_err_q  <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      acc_exc    <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      bus_err_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= BUSY;
            wr_q    <= req_write;
            f3_q    <= req_funct3;
            MREQ    <= 1'b1;
            WRITE   <= req_write;
            SIZE    <= size_c;
            DAD     <= req_addr;
            DDT_out <= wfmt;
`ifdef DBUS_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end else if (req_valid) begin
            acc_exc <= 1'b1;
          end
        end
        BUSY: begin
          if (!ACKD_n) begin
            state      <= RESP;
            MREQ       <= 1'b0;
            WRITE      <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= rext;
`ifdef DBUS_TIMEOUT_EN
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= IDLE;
            MREQ      <= 1'b0;
            WRITE     <= 1'b0;
            bus_err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_bus_if.md
Name: dmem_bus_if

Overview:
Load/store bus interface between the pipeline MEM stage and the external data-memory bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Converts a MEM-stage access (funct3-encoded size and sign) into one handshaked bus transaction.
- Stalls the pipeline until the memory acknowledges.
- Returns sign- or zero-extended load data.
- Flags misaligned or illegal accesses without touching the bus.

Parameters:
- XLEN, 32, data/address width
- TIMEOUT_CYCLES, 255, max wait cycles for ACKD_n (used only with DBUS_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  MEM stage has a load/store this cycle
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data (LSBs significant)
- stall  out  1  hold pipeline
- resp_valid  out  1  one-cycle pulse: access completed
- resp_rdata  out  XLEN  extended load data (valid with resp_valid on loads)
- acc_exc  out  1  one-cycle pulse: misaligned/illegal access
- bus_err  out  1  one-cycle pulse: timeout abort
- DAD  out  XLEN  bus address
- DDT_out  out  XLEN  bus write data
- DDT_oe  out  1  drive DDT (= MREQ & WRITE)
- DDT_in  in  XLEN  bus read data
- MREQ  out  1  bus request
- WRITE  out  1  bus write
- SIZE  out  2  00 word, 01 half, 10 byte
- ACKD_n  in  1  active-low acknowledge

Behaviour:
- Reset:
  - state IDLE.
  - MREQ, WRITE, DDT_oe, stall, resp_valid, acc_exc and bus_err all 0.
  - DAD, DDT_out and resp_rdata all 0.
  - SIZE = 00.
- FSM states: IDLE, BUSY, RESP.
- IDLE, req_valid=1, access legal:
  - Latch addr, write, funct3, formatted wdata.
  - Next cycle enter BUSY with MREQ=1, DAD=addr, WRITE, SIZE from funct3[1:0].
  - stall=1 combinationally in this cycle.
- IDLE, req_valid=1, access illegal:
  - Illegal = half with addr[0]=1; word with addr[1:0]≠0; load funct3 ∈ {011,110,111}; store funct3 > 010.
  - acc_exc pulses next cycle; no bus cycle; stall=0.
- BUSY:
  - stall=1; bus outputs held stable.
  - Sample ACKD_n each rising edge.
  - ACKD_n=0: capture DDT_in, drop MREQ/WRITE next cycle, go RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_rdata valid; stall=0.
  - Return to IDLE.
  - A new request is not accepted in RESP, so back-to-back accesses are ≥3 cycles apart.
- Minimum latency: accept→resp_valid = 3 cycles with ACKD_n low in the first BUSY cycle.
- Store formatting:
  - word: DDT_out = wdata.
  - half: DDT_out = {16'h0, wdata[15:0]}.
  - byte: DDT_out = {24'h0, wdata[7:0]}.
- Load extraction:
  - LB: sext DDT_in[7:0]; LBU: zext DDT_in[7:0].
  - LH: sext DDT_in[15:0]; LHU: zext DDT_in[15:0].
  - LW: DDT_in.
  - Stores return resp_rdata=0.
- Bus protocol:
  - ACKD_n low while IDLE/RESP is ignored.
  - Changes on req_* while BUSY are ignored; the latched transaction completes.
- rst asserted in any state → IDLE at that edge, MREQ=0, no resp_valid; a pending ACKD_n is discarded.

Optional Feature:
DBUS_TIMEOUT_EN
- Defined:
  - Counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the transaction aborts: MREQ=0 next cycle, bus_err pulses one cycle, stall drops, state IDLE, no resp_valid.
  - An ack on the same edge as the limit wins: normal completion.
- Undefined: no counter; BUSY waits indefinitely; bus_err tied 0.

Test Plan:
- LW addr 0x08000010, ACKD_n low 1st BUSY cycle, DDT_in=0xDEADBEEF → MREQ=1/WRITE=0/SIZE=00/DAD=0x08000010 for 1 cycle; resp_valid 3 cycles after accept; resp_rdata=0xDEADBEEF; stall high 2 cycles.
- LB then LBU, DDT_in=0x00000080 → 0xFFFFFF80 then 0x00000080; LH with DDT_in=0x00008001 → 0xFFFF8001.
- SB addr 0xF0000000 wdata=0x12345641, ACKD_n delayed 4 cycles → DDT_oe=1, DDT_out=0x00000041, SIZE=10; bus signals stable through all BUSY cycles; stall held until ack.
- LW addr 0x08000002; SH addr 0x08000003 → acc_exc pulse each, MREQ never asserted, stall=0.
- rst in 2nd BUSY cycle, ACKD_n low same edge → MREQ=0, no resp_valid, state IDLE; next LW completes normally.
- With DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, ACKD_n held high → bus_err pulse after 4 BUSY cycles, MREQ=0, stall=0; without the macro, stall stays high for 100 cycles.
